// File: rtl/digit_serial_addsub.sv
// ============================================================================
// Module      : digit_serial_addsub
// Description : Digit-serial N-bit adder/subtractor, K bits per clock.
//               Optional zero flag enabled by defining ADDSUB_ZERO_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_serial_addsub #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
`ifdef ADDSUB_ZERO_FLAG_EN
  ,
  output logic         Zero
`endif
);

  localparam int ND = N / K;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [CW-1:0] c_LAST = CW'(ND - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_bx;
  logic [N-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;

  logic          w_accept;
  logic          w_last;
  logic [K-1:0]  w_adig;
  logic [K-1:0]  w_bdig;
  logic [K:0]    w_slice;
  logic          w_msb_cin;

  // Start is honoured everywhere except mid-operation, enabling back-to-back ops from DONE.
  assign w_accept = start && (r_state != c_RUN);
  assign w_last   = (r_cnt == c_LAST);

  always_comb begin
    w_adig    = r_a[r_cnt * K +: K];
    w_bdig    = r_bx[r_cnt * K +: K];
    w_slice   = {1'b0, w_adig} + {1'b0, w_bdig} + (K + 1)'(r_carry);
    // Carry into the slice MSB; on the last digit this is the carry into bit N-1.
    w_msb_cin = w_adig[K-1] ^ w_bdig[K-1] ^ w_slice[K-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_bx    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_bx    <= B ^ {N{Sub}};
      r_carry <= Cin ^ Sub;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_state <= c_RUN;
    end else begin
      case (r_state)
        c_RUN: begin
          r_sum[r_cnt * K +: K] <= w_slice[K-1:0];
          r_carry               <= w_slice[K];
          if (w_last) begin
            r_cnt   <= '0;
            r_cout  <= w_slice[K];
            r_ovf   <= w_msb_cin ^ w_slice[K];
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef ADDSUB_ZERO_FLAG_EN
  logic r_nz;
  logic r_zero;

  // Running OR of written digits avoids a full-width compare at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nz   <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_nz   <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == c_RUN) begin
      r_nz <= r_nz | (|w_slice[K-1:0]);
      if (w_last) begin
        r_zero <= ~(r_nz | (|w_slice[K-1:0]));
      end
    end
  end

  assign Zero = r_zero;
`endif

  assign busy = (r_state == c_RUN);
  assign done = (r_state == c_DONE);
  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
// ============================================================================
// Module      : tb_digit_serial_addsub
// Description : Directed self-checking bench for digit_serial_addsub (N=16, K=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_digit_serial_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic        zero;
`endif

  int checks = 0;
  int errors = 0;

  digit_serial_addsub #(.N(16), .K(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .Sub   (sub),
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Cout  (cout),
    .Ovf   (ovf)
`ifdef ADDSUB_ZERO_FLAG_EN
    ,
    .Zero  (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vs);
    a     = va;
    b     = vb;
    cin   = vc;
    sub   = vs;
    start = 1'b1;
  endtask

  // Called on the negedge before the accepting edge; returns on the negedge where done is seen.
  // pulse_at > 0 re-asserts start (with junk operands) during that RUN cycle.
  task automatic wait_done(input int pulse_at);
    int k;
    int busy_cnt;
    k = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      k++;
      if (k == 1) start = 1'b0;
      if (k == pulse_at) begin
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      end
      if (k == pulse_at + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done || k > 20) break;
    end
    chk("latency", k - 1, 4);
    chk("busy_cycles", busy_cnt, 4);
  endtask

  task automatic check_result(input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("ovf", ovf, eo);
`ifdef ADDSUB_ZERO_FLAG_EN
    chk("zero", zero, ez);
`else
    if (ez === 1'bx) chk("zero_arg", ez, 1'b0);
`endif
  endtask

  task automatic check_after(input logic [15:0] es);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("sum_hold", sum, es);
  endtask

  task automatic op(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vs,
                    input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    drive(va, vb, vc, vs);
    wait_done(0);
    check_result(es, ec, eo, ez);
    check_after(es);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    // Basic add, carry and overflow boundaries
    op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

    // Subtract, including borrow-in
    op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    op(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);

    // Start during RUN is ignored
    @(negedge clk);
    drive(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(2);
    check_result(16'h5555, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_second_done", done, 1'b0);
      chk("no_restart", busy, 1'b0);
    end

    // Back-to-back: start held in DONE
    @(negedge clk);
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(0);
    check_result(16'h8000, 1'b0, 1'b1, 1'b0);
    drive(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_done(0);
    check_result(16'h0003, 1'b0, 1'b0, 1'b0);
    check_after(16'h0003);

    // Asynchronous reset during RUN cycle 2
    @(negedge clk);
    drive(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    chk("mid_sum_digit0", sum, 16'h0005);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_sum", sum, 16'h0000);
    chk("arst_cout", cout, 1'b0);
    chk("arst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 1'b0);
    op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised multi-cycle successor to the combinational ripple-carry adder.
- Adds or subtracts two N-bit operands K bits per clock.
- A K-bit full-adder slice is reused, with the carry held in a register between digits.
- Trades latency (N/K clocks) for area. Used where a wide combinational carry chain would not meet timing. Start/busy/done handshake.

Parameters:
- N, 16, operand and result width in bits; must be a multiple of K, N >= 2.
- K, 4, digit width processed per clock; 1 <= K <= N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on the rising edge of clk.
- A  input  N  operand A; sampled only on an accepted start.
- B  input  N  operand B; sampled only on an accepted start.
- Cin  input  1  carry-in (borrow-in when Sub=1); sampled only on an accepted start.
- Sub  input  1  0 = add, 1 = subtract; sampled only on an accepted start.
- busy  output  1  high while digits are being processed (RUN state).
- done  output  1  one-cycle pulse: results are final.
- Sum  output  N  result.
- Cout  output  1  carry out of the MSB.
- Ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high.
  - While rst=1: state=IDLE, digit counter=0, carry register=0, operand registers=0.
  - Outputs during reset: busy=0, done=0, Sum=0, Cout=0, Ovf=0.
  - Reset mid-operation aborts immediately. No partial result is retained.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Accept rule: start is accepted in IDLE or DONE. It is ignored in RUN; operands are not resampled and no error is flagged.
- On accept (same clock edge):
  - Latch A.
  - Latch Bx = B XOR {N{Sub}}.
  - carry <= Cin XOR Sub.
  - Digit counter <= 0; state -> RUN.
  - Clear Sum, Cout and Ovf to 0.
  - Semantics: Sub=1, Cin=0 gives A-B; Sub=1, Cin=1 gives A-B-1.
- RUN, each edge, for digit d = counter (bits d*K+K-1 : d*K):
  - Slice result = A_digit + Bx_digit + carry.
  - Write the slice sum into Sum[d*K+K-1 : d*K].
  - carry <= carry out of the slice; counter <= counter+1.
  - Higher Sum digits stay 0 until written. Sum is only defined for use when done=1.
- Last digit (d = N/K-1), on the same edge:
  - Cout <= carry out of bit N-1.
  - Ovf <= (carry into bit N-1) XOR (carry out of bit N-1).
  - State -> DONE.
- DONE:
  - Next edge goes to IDLE, or to RUN if start=1 (back-to-back operation, no bubble).
  - Sum, Cout and Ovf hold their values until the next accepted start or reset.
- Latency: done is high in the cycle beginning exactly N/K rising edges after the edge that accepted start.
  - Throughput: one result per N/K clocks.
- Case K=N: single RUN cycle, latency 1.
- Subtract flags: Cout=1 means no borrow (A >= B unsigned, when Cin=0). Ovf uses the standard signed rule.
- Counter width: clog2(N/K), minimum 1 bit. It wraps to 0 on leaving RUN.

Optional Feature:
- Macro: ADDSUB_ZERO_FLAG_EN.
- When defined:
  - Extra output port Zero (output, 1 bit).
  - Zero is cleared to 0 on reset and on accepted start.
  - It is set with the final digit to 1 iff the full N-bit Sum == 0.
  - It is accumulated per digit as a running OR of slice sums, with no separate N-bit compare.
  - It is held with Sum.
- When undefined: no Zero port and no associated logic. All other behaviour is identical.

Test Plan:
All scenarios use N=16, K=4, so latency is 4 clocks.
1. Start with A=0x1234, B=0x4321, Cin=0, Sub=0 -> busy high for 4 cycles, then done=1 for one cycle; Sum=0x5555, Cout=0, Ovf=0 (Zero=0 when enabled).
2. A=0xFFFF, B=0x0001, add -> Sum=0x0000, Cout=1, Ovf=0, Zero=1. Separately, A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Ovf=1.
3. Subtract: A=0x0005, B=0x0007, Sub=1, Cin=0 -> Sum=0xFFFE, Cout=0, Ovf=0. Then A=0x8000, B=0x0001, Sub=1 -> Sum=0x7FFF, Cout=1, Ovf=1.
4. start pulsed again in RUN cycle 2 with different operands -> ignored; the result of the first operation is unchanged and done comes at the original cycle only.
5. start held high in the DONE cycle with A=0x0001, B=0x0002 -> first result is visible during done, the new operation starts with no idle cycle, and 4 clocks later Sum=0x0003.
6. rst asserted asynchronously (between edges) during RUN cycle 2 -> busy, done, Sum, Cout and Ovf go to 0 immediately. After release, a fresh start completes normally with correct values.
